// File: rtl/stack_unit_pkg.sv
// Shared types and constants for the stack engine: FSM state encoding,
// OP codes and default page/reset values.
package stack_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_HI = 3'd1,
    S_PUSH_LO = 3'd2,
    S_PULL_LO = 3'd3,
    S_PULL_HI = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH1 = 2'b00,
    OP_PUSH2 = 2'b01,
    OP_PULL1 = 2'b10,
    OP_PULL2 = 2'b11
  } op_t;

  localparam logic [7:0] STACK_PAGE_DEF = 8'h01;
  localparam logic [7:0] SP_RESET_DEF   = 8'hFF;

  function automatic logic [15:0] stack_addr(input logic [7:0] page, input logic [7:0] s);
    return {page, s};
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Bundle of CPU-side request/response and memory-side signals of the stack engine.
// master: the CPU plus memory side; slave: the stack engine.
interface stack_unit_if;
  logic        START;
  logic [1:0]  OP;
  logic [15:0] DIN;
  logic        WR_SP;
  logic [7:0]  SP_IN;
  logic [7:0]  RDATA;
  logic        BUSY;
  logic        DONE;
  logic [15:0] DOUT;
  logic [7:0]  SP;
  logic [15:0] ADDR;
  logic [7:0]  WDATA;
  logic        WE;
  logic        OVF;

  modport master (
    output START, OP, DIN, WR_SP, SP_IN, RDATA,
    input  BUSY, DONE, DOUT, SP, ADDR, WDATA, WE, OVF
  );

  modport slave (
    input  START, OP, DIN, WR_SP, SP_IN, RDATA,
    output BUSY, DONE, DOUT, SP, ADDR, WDATA, WE, OVF
  );
endinterface

// File: rtl/stack_unit_sp_counter.sv
// 8-bit stack pointer register: sync reset, load, increment, decrement.
// Load wins; inc and dec are never requested together.
module sp_counter #(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp
);

  always_ff @(posedge CLK) begin
    if (R)        sp <= SP_RESET;
    else if (load) sp <= load_val;
    else if (inc)  sp <= sp + 8'd1;
    else if (dec)  sp <= sp - 8'd1;
  end

endmodule

// File: rtl/stack_unit.sv
// Stack engine: sequences 1/2-byte pushes and pulls on the stack page.
// Optional sticky wrap flag on OVF when STACK_OVF_EN is defined.
module stack_unit
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF,
  parameter logic [7:0] SP_RESET   = SP_RESET_DEF
) (
  input logic         CLK,
  input logic         R,
  stack_unit_if.slave bus
);

  state_t      state;
  op_t         op_q;
  logic [15:0] din_q;
  logic [7:0]  lo_q;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic        we;
  logic [7:0]  sp;
  logic        sp_load;
  logic        sp_inc;
  logic        sp_dec;

  assign sp_load = (state == S_IDLE) && bus.WR_SP;
  assign sp_inc  = (state == S_PULL_LO) || (state == S_PULL_HI);
  assign sp_dec  = (state == S_PUSH_HI) || (state == S_PUSH_LO);

  sp_counter #(.SP_RESET(SP_RESET)) u_sp (
    .CLK      (CLK),
    .R        (R),
    .load     (sp_load),
    .load_val (bus.SP_IN),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp)
  );

  always_ff @(posedge CLK) begin
    if (R) begin
      state <= S_IDLE;
      op_q  <= OP_PUSH1;
      din_q <= 16'h0000;
      lo_q  <= 8'h00;
      dout  <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
      we    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.WR_SP && bus.START) begin
            op_q  <= op_t'(bus.OP);
            din_q <= bus.DIN;
            busy  <= 1'b1;
            case (op_t'(bus.OP))
              OP_PUSH1: begin state <= S_PUSH_LO; we <= 1'b1; end
              OP_PUSH2: begin state <= S_PUSH_HI; we <= 1'b1; end
              default:  state <= S_PULL_LO;
            endcase
          end
        end
        S_PUSH_HI: state <= S_PUSH_LO;
        S_PUSH_LO: begin
          state <= S_FIN;
          we    <= 1'b0;
          done  <= 1'b1;
        end
        S_PULL_LO: begin
          // the low byte of a pull2 is held aside so DOUT changes only on completion
          if (op_q == OP_PULL2) begin
            lo_q  <= bus.RDATA;
            state <= S_PULL_HI;
          end else begin
            dout  <= {8'h00, bus.RDATA};
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_PULL_HI: begin
          dout  <= {bus.RDATA, lo_q};
          state <= S_FIN;
          done  <= 1'b1;
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.ADDR = stack_addr(STACK_PAGE, sp);
    if (sp_inc) bus.ADDR = stack_addr(STACK_PAGE, sp + 8'd1);
  end

  assign bus.WDATA = (state == S_PUSH_HI) ? din_q[15:8] : din_q[7:0];
  assign bus.WE    = we;
  assign bus.BUSY  = busy;
  assign bus.DONE  = done;
  assign bus.DOUT  = dout;
  assign bus.SP    = sp;

`ifdef STACK_OVF_EN
  logic ovf;

  always_ff @(posedge CLK) begin
    if (R)            ovf <= 1'b0;
    else if (sp_load) ovf <= 1'b0;
    else if ((sp_dec && sp == 8'h00) || (sp_inc && sp == 8'hFF)) ovf <= 1'b1;
  end

  assign bus.OVF = ovf;
`else
  assign bus.OVF = 1'b0;
`endif

endmodule
